fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of decode.
- Owns the PC register and issues requests to instruction memory, which may have variable latency.
- Holds one fetched instruction plus its PC+2 in a single output slot, handed to decode under a stall handshake.
- Accepts branch/jump redirects from execute, squashing wrong-path work; stops fetching at HALT.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_if.sv | 24 ++
 rtl/fetch_pc_reg.sv | 40 ++++
 rtl/fetch_unit.sv | 156 +++++++++++++++
 tb/tb_fetch_unit.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned ILEN = 16;

    // instr[15:11] value that stops fetch
    localparam logic [4:0] OPCODE_HALT = 5'b00000;

    localparam logic [ILEN-1:0] RESET_PC_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        StRun,
        StWaitMem,
        StHalted
    } state_e;

    function automatic logic is_halt(input logic [ILEN-1:0] instr, input logic [4:0] opcode);
        return instr[ILEN-1:ILEN-5] == opcode;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response bus between fetch (master) and imem (slave).
interface fetch_if;
    import fetch_pkg::*;

    logic            req;
    logic [ILEN-1:0] addr;
    logic            ready;
    logic [ILEN-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  ready,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ready,
        output rdata
    );

endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter with next-PC selection: redirect target, sequential +2, or hold.
// The +2 increment wraps modulo 2^16 with no carry out.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter logic [ILEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic            advance,
    input  logic [ILEN-1:0] target,
    output logic [ILEN-1:0] pc,
    output logic [ILEN-1:0] pc_inc
);

    logic [ILEN-1:0] pc_next;

    assign pc_inc = pc + ILEN'(2);

    // Redirect wins over sequential advance; otherwise hold.
    always_comb begin
        pc_next = pc;
        if (redirect) begin
            pc_next = target;
        end else if (advance) begin
            pc_next = pc_inc;
        end
    end

    // PC register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks to variable-latency imem, and
// presents one instruction plus its PC+2 to decode under a stall handshake.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (odd redirect target raises a
// sticky err and suppresses fetch until the next aligned redirect).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [ILEN-1:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter logic [4:0]      HALT_OPCODE = OPCODE_HALT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_in,
    input  logic            redirect_en,
    input  logic [ILEN-1:0] redirect_pc,
    fetch_if.master         imem,
    output logic [ILEN-1:0] instr_out,
    output logic [ILEN-1:0] pc_plus2,
    output logic            instr_valid,
    output logic            halt_out,
    output logic            err
);

    state_e          state;
    logic            drop;
    logic            blocked;
    logic [ILEN-1:0] pc;
    logic [ILEN-1:0] pc_inc;
    logic [ILEN-1:0] redirect_target;

    logic consume;
    logic slot_free;
    logic slot_halt;
    logic redirect_take;
    logic load;

    assign consume       = instr_valid & ~stall_in;
    assign slot_free     = ~instr_valid | consume;
    assign slot_halt     = instr_valid & is_halt(instr_out, HALT_OPCODE);
    assign redirect_take = redirect_en & (state != StHalted);
    // A response returning for an abandoned request never reaches the slot.
    assign load          = imem.req & imem.ready & ~((state == StWaitMem) & drop);

`ifdef FETCH_ALIGN_CHECK_EN
    assign redirect_target = {redirect_pc[ILEN-1:1], 1'b0};

    // Sticky misalignment flag; blocked holds fetch off until an aligned redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            err     <= 1'b0;
            blocked <= 1'b0;
        end else if (redirect_take) begin
            if (redirect_pc[0]) begin
                err     <= 1'b1;
                blocked <= 1'b1;
            end else begin
                blocked <= 1'b0;
            end
        end
    end
`else
    assign redirect_target = redirect_pc;
    assign err             = 1'b0;
    assign blocked         = 1'b0;
`endif

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .redirect (redirect_take),
        .advance  (load),
        .target   (redirect_target),
        .pc       (pc),
        .pc_inc   (pc_inc)
    );

    assign imem.addr = pc;

    // Request qualification; a redirect cycle never issues a request.
    always_comb begin
        imem.req = 1'b0;
        case (state)
            StRun:     imem.req = slot_free & ~slot_halt & ~redirect_en & ~blocked;
            StWaitMem: imem.req = ~redirect_en;
            default:   imem.req = 1'b0;
        endcase
    end

    // Fetch FSM with registered slot and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StRun;
            drop        <= 1'b0;
            instr_valid <= 1'b0;
            instr_out   <= '0;
            pc_plus2    <= '0;
            halt_out    <= 1'b0;
        end else begin
            case (state)
                StRun: begin
                    if (redirect_en) begin
                        instr_valid <= 1'b0;
                    end else if (slot_halt && consume) begin
                        state       <= StHalted;
                        halt_out    <= 1'b1;
                        instr_valid <= 1'b0;
                    end else if (load) begin
                        instr_out   <= imem.rdata;
                        pc_plus2    <= pc_inc;
                        instr_valid <= 1'b1;
                    end else begin
                        if (imem.req) begin
                            state <= StWaitMem;
                        end
                        if (consume) begin
                            instr_valid <= 1'b0;
                        end
                    end
                end
                StWaitMem: begin
                    if (redirect_en) begin
                        instr_valid <= 1'b0;
                        if (imem.ready) begin
                            // Outstanding response lands now and is thrown away.
                            state <= StRun;
                            drop  <= 1'b0;
                        end else begin
                            drop <= 1'b1;
                        end
                    end else if (imem.ready) begin
                        state <= StRun;
                        drop  <= 1'b0;
                        if (load) begin
                            instr_out   <= imem.rdata;
                            pc_plus2    <= pc_inc;
                            instr_valid <= 1'b1;
                        end else if (consume) begin
                            instr_valid <= 1'b0;
                        end
                    end else if (consume) begin
                        instr_valid <= 1'b0;
                    end
                end
                StHalted: begin
                    instr_valid <= 1'b0;
                end
                default: begin
                    state <= StRun;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk;
    logic        rst;
    logic        stall_in;
    logic        redirect_en;
    logic [15:0] redirect_pc;
    logic [15:0] instr_out;
    logic [15:0] pc_plus2;
    logic        instr_valid;
    logic        halt_out;
    logic        err;

    logic        ovr_en;
    logic [15:0] ovr_addr;
    logic [15:0] ovr_word;
    logic [15:0] mem_word;

    int total;
    int bad;

    fetch_if bus ();

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .stall_in    (stall_in),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .imem        (bus.master),
        .instr_out   (instr_out),
        .pc_plus2    (pc_plus2),
        .instr_valid (instr_valid),
        .halt_out    (halt_out),
        .err         (err)
    );

    // Memory image: 16'h4000 | addr, with one overridable word.
    always_comb begin
        mem_word = 16'h4000 | bus.addr;
        if (ovr_en && bus.addr == ovr_addr) mem_word = ovr_word;
    end
    assign bus.rdata = mem_word;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst         = 1'b1;
        stall_in    = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = 16'h0000;
        bus.ready   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall_in = 1'b0; redirect_en = 1'b1; redirect_pc = 16'h1234;
        bus.ready = 1'b1; ovr_en = 1'b0;
        tick();
        tick();
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
        total++; if (instr_out !== 16'h0000) begin bad++; $display("FAIL rst_instr got=%h exp=0000", instr_out); end
        total++; if (pc_plus2 !== 16'h0000) begin bad++; $display("FAIL rst_pcp2 got=%h exp=0000", pc_plus2); end
        total++; if (halt_out !== 1'b0) begin bad++; $display("FAIL rst_halt got=%b exp=0", halt_out); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err); end
        rst = 1'b0; redirect_en = 1'b0; bus.ready = 1'b0;
        #1;
        total++; if (bus.req !== 1'b1) begin bad++; $display("FAIL rst_req got=%b exp=1", bus.req); end
        total++; if (bus.addr !== 16'h0000) begin bad++; $display("FAIL rst_addr got=%h exp=0000", bus.addr); end
    endtask

    task automatic test_stream();
        logic [15:0] ea;
        apply_reset();
        bus.ready = 1'b1;
        #1;
        total++; if (bus.addr !== 16'h0000) begin bad++; $display("FAIL stream_addr0 got=%h exp=0000", bus.addr); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            ea = 16'(2 * i);
            total++; if (bus.addr !== ea) begin bad++; $display("FAIL stream_addr got=%h exp=%h", bus.addr, ea); end
            total++; if (pc_plus2 !== ea) begin bad++; $display("FAIL stream_pcp2 got=%h exp=%h", pc_plus2, ea); end
            total++; if (instr_out !== (16'h4000 | (ea - 16'd2))) begin bad++; $display("FAIL stream_instr got=%h exp=%h", instr_out, 16'h4000 | (ea - 16'd2)); end
            total++; if (instr_valid !== 1'b1 || bus.req !== 1'b1) begin bad++; $display("FAIL stream_vld_req got=%b%b exp=11", instr_valid, bus.req); end
        end
    endtask

    task automatic test_wait();
        apply_reset();
        bus.ready = 1'b1;
        tick();
        tick();
        bus.ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            total++; if (bus.req !== 1'b1 || bus.addr !== 16'h0004) begin bad++; $display("FAIL wait_hold got=%b/%h exp=1/0004", bus.req, bus.addr); end
            tick();
            total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL wait_valid got=%b exp=0", instr_valid); end
        end
        bus.ready = 1'b1;
        tick();
        total++; if (instr_valid !== 1'b1 || instr_out !== 16'h4004) begin bad++; $display("FAIL wait_load got=%b/%h exp=1/4004", instr_valid, instr_out); end
        total++; if (pc_plus2 !== 16'h0006 || bus.addr !== 16'h0006) begin bad++; $display("FAIL wait_pc got=%h/%h exp=0006/0006", pc_plus2, bus.addr); end
    endtask

    task automatic test_stall();
        apply_reset();
        ovr_en = 1'b1; ovr_addr = 16'h0000; ovr_word = 16'hA123;
        bus.ready = 1'b1;
        tick();
        stall_in = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            total++; if (bus.req !== 1'b0) begin bad++; $display("FAIL stall_req got=%b exp=0", bus.req); end
            tick();
            total++; if (instr_out !== 16'hA123 || instr_valid !== 1'b1) begin bad++; $display("FAIL stall_slot got=%h/%b exp=a123/1", instr_out, instr_valid); end
            total++; if (bus.addr !== 16'h0002 || pc_plus2 !== 16'h0002) begin bad++; $display("FAIL stall_pc got=%h/%h exp=0002/0002", bus.addr, pc_plus2); end
        end
        stall_in = 1'b0;
        ovr_en = 1'b0;
        tick();
        total++; if (instr_out !== 16'h4002 || pc_plus2 !== 16'h0004) begin bad++; $display("FAIL stall_resume got=%h/%h exp=4002/0004", instr_out, pc_plus2); end
    endtask

    task automatic test_redirect_wait();
        apply_reset();
        bus.ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        bus.ready = 1'b0;
        #1;
        total++; if (bus.addr !== 16'h0010) begin bad++; $display("FAIL rdw_addr got=%h exp=0010", bus.addr); end
        tick();
        redirect_en = 1'b1; redirect_pc = 16'h0100;
        #1;
        total++; if (bus.req !== 1'b0) begin bad++; $display("FAIL rdw_noreq got=%b exp=0", bus.req); end
        tick();
        redirect_en = 1'b0;
        tick();
        bus.ready = 1'b1;
        tick();
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rdw_discard got=%b exp=0", instr_valid); end
        total++; if (bus.req !== 1'b1 || bus.addr !== 16'h0100) begin bad++; $display("FAIL rdw_next got=%b/%h exp=1/0100", bus.req, bus.addr); end
        tick();
        total++; if (instr_out !== 16'h4100 || pc_plus2 !== 16'h0102) begin bad++; $display("FAIL rdw_load got=%h/%h exp=4100/0102", instr_out, pc_plus2); end
        // Response coinciding with the redirect: discarded, no lingering drop.
        bus.ready = 1'b0;
        tick();
        redirect_en = 1'b1; redirect_pc = 16'h0200; bus.ready = 1'b1;
        tick();
        redirect_en = 1'b0;
        #1;
        total++; if (instr_valid !== 1'b0 || bus.addr !== 16'h0200) begin bad++; $display("FAIL rdw_coin got=%b/%h exp=0/0200", instr_valid, bus.addr); end
        tick();
        total++; if (instr_valid !== 1'b1 || instr_out !== 16'h4200) begin bad++; $display("FAIL rdw_coin_load got=%b/%h exp=1/4200", instr_valid, instr_out); end
    endtask

    task automatic test_halt();
        apply_reset();
        ovr_en = 1'b1; ovr_addr = 16'h0008; ovr_word = 16'h0000;
        bus.ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        stall_in = 1'b1;
        #1;
        total++; if (instr_out !== 16'h0000 || pc_plus2 !== 16'h000A) begin bad++; $display("FAIL halt_slot got=%h/%h exp=0000/000a", instr_out, pc_plus2); end
        total++; if (bus.req !== 1'b0) begin bad++; $display("FAIL halt_noreq got=%b exp=0", bus.req); end
        tick();
        stall_in = 1'b0;
        #1;
        total++; if (bus.req !== 1'b0 || halt_out !== 1'b0) begin bad++; $display("FAIL halt_pre got=%b/%b exp=0/0", bus.req, halt_out); end
        tick();
        total++; if (halt_out !== 1'b1 || instr_valid !== 1'b0) begin bad++; $display("FAIL halt_set got=%b/%b exp=1/0", halt_out, instr_valid); end
        redirect_en = 1'b1; redirect_pc = 16'h0040;
        #1;
        total++; if (bus.req !== 1'b0) begin bad++; $display("FAIL halt_redir_req got=%b exp=0", bus.req); end
        tick();
        redirect_en = 1'b0;
        tick();
        total++; if (halt_out !== 1'b1 || bus.addr !== 16'h000A || instr_valid !== 1'b0) begin bad++; $display("FAIL halt_sticky got=%b/%h/%b exp=1/000a/0", halt_out, bus.addr, instr_valid); end
        apply_reset();
        total++; if (halt_out !== 1'b0) begin bad++; $display("FAIL halt_clear got=%b exp=0", halt_out); end
        // HALT squashed by a redirect before it is consumed.
        bus.ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        stall_in = 1'b1;
        redirect_en = 1'b1; redirect_pc = 16'h0020;
        tick();
        redirect_en = 1'b0; stall_in = 1'b0;
        #1;
        total++; if (instr_valid !== 1'b0 || bus.req !== 1'b1 || bus.addr !== 16'h0020) begin bad++; $display("FAIL squash got=%b/%b/%h exp=0/1/0020", instr_valid, bus.req, bus.addr); end
        tick();
        tick();
        total++; if (halt_out !== 1'b0 || instr_out !== 16'h4022 || pc_plus2 !== 16'h0024) begin bad++; $display("FAIL squash_run got=%b/%h/%h exp=0/4022/0024", halt_out, instr_out, pc_plus2); end
        ovr_en = 1'b0;
    endtask

    task automatic test_wrap();
        apply_reset();
        bus.ready = 1'b1;
        redirect_en = 1'b1; redirect_pc = 16'hFFFE;
        tick();
        redirect_en = 1'b0;
        #1;
        total++; if (bus.addr !== 16'hFFFE) begin bad++; $display("FAIL wrap_addr got=%h exp=fffe", bus.addr); end
        tick();
        total++; if (instr_out !== 16'hFFFE || pc_plus2 !== 16'h0000 || bus.addr !== 16'h0000) begin bad++; $display("FAIL wrap got=%h/%h/%h exp=fffe/0000/0000", instr_out, pc_plus2, bus.addr); end
    endtask

    task automatic test_align();
        apply_reset();
        bus.ready = 1'b1;
        tick();
        redirect_en = 1'b1; redirect_pc = 16'h0103;
        tick();
        redirect_en = 1'b0;
        #1;
`ifdef FETCH_ALIGN_CHECK_EN
        total++; if (err !== 1'b1 || bus.addr !== 16'h0102 || bus.req !== 1'b0) begin bad++; $display("FAIL align_err got=%b/%h/%b exp=1/0102/0", err, bus.addr, bus.req); end
        tick();
        redirect_en = 1'b1; redirect_pc = 16'h0200;
        tick();
        redirect_en = 1'b0;
        #1;
        total++; if (err !== 1'b1 || bus.req !== 1'b1 || bus.addr !== 16'h0200) begin bad++; $display("FAIL align_sticky got=%b/%b/%h exp=1/1/0200", err, bus.req, bus.addr); end
        apply_reset();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL align_clear got=%b exp=0", err); end
`else
        total++; if (err !== 1'b0 || bus.addr !== 16'h0103 || bus.req !== 1'b1) begin bad++; $display("FAIL align_off got=%b/%h/%b exp=0/0103/1", err, bus.addr, bus.req); end
`endif
    endtask

    initial begin
        total = 0;
        bad = 0;
        ovr_en = 1'b0;
        ovr_addr = 16'h0000;
        ovr_word = 16'h0000;
        test_reset();
        test_stream();
        test_wait();
        test_stall();
        test_redirect_wait();
        test_halt();
        test_wrap();
        test_align();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
